// File: rtl/rbz_spi_pkg.sv
// Shared definitions for the rbzero SPI master: command width,
// rbzero command codes and the controller state encoding.
package rbz_spi_pkg;

  // Width of the command field that leads every frame.
  localparam int CMD_W = 4;

  // rbzero slave-port command codes.
  localparam logic [CMD_W-1:0] CMD_REG_WRITE  = 4'h0;
  localparam logic [CMD_W-1:0] CMD_VEC_WRITE  = 4'h1;
  localparam logic [CMD_W-1:0] CMD_REG_BURST  = 4'h2;
  localparam logic [CMD_W-1:0] CMD_VEC_RESET  = 4'hF;

  // Controller states; each non-IDLE state lasts one programmable phase.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/rbz_spi_phase_timer.sv
// Phase timer: down-counter reloaded with DIV-1 on load_i.
// tick_o is high in the last cycle of a DIV-cycle phase.
module rbz_spi_phase_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("rbz_spi_phase_timer: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on a state change, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/rbz_spi_master.sv
// Mode-0 SPI master that serialises {command, payload} register-write
// frames for the rbzero slave ports. One frame per valid/ready handshake.
module rbz_spi_master #(
  parameter int CMD_W  = rbz_spi_pkg::CMD_W,
  parameter int DATA_W = 64,
  parameter int DIV    = 4,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CMD_W-1:0]  i_cmd,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  output logic              o_done,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_ss_n
);

  import rbz_spi_pkg::*;

  localparam int SR_W  = CMD_W + DATA_W;
  localparam int REM_W = $clog2(SR_W + 1);

  if (DIV < 2) begin : g_div_check
    $error("rbz_spi_master: DIV must be at least 2");
  end

  spi_state_e       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ss_n_q, ss_n_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             tmr_load;
  logic             tmr_tick;

  logic [LEN_W-1:0]  len_eff;
  logic [DATA_W-1:0] data_al;
  logic [REM_W-1:0]  n_bits;

  rbz_spi_phase_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .tick_o (tmr_tick)
  );

  // Clamp the length and left-align the payload so the first payload bit
  // follows the command LSB directly in the shift register.
  always_comb begin
    len_eff = (i_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : i_len;
    data_al = i_data << (LEN_W'(DATA_W) - len_eff);
    n_bits  = REM_W'(CMD_W) + REM_W'(len_eff);
  end

  // Next-state and registered-output logic; every transition reloads the timer.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    rem_d    = rem_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ss_n_d   = ss_n_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          state_d  = SETUP;
          sr_d     = {i_cmd, data_al};
          rem_d    = n_bits;
          ss_n_d   = 1'b0;
          sclk_d   = 1'b0;
          mosi_d   = i_cmd[CMD_W-1];
          ready_d  = 1'b0;
          tmr_load = 1'b1;
        end
      end
      SETUP: begin
        if (tmr_tick) begin
          state_d  = HIGH;
          sclk_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      HIGH: begin
        if (tmr_tick) begin
          sclk_d   = 1'b0;
          tmr_load = 1'b1;
          if (rem_q > REM_W'(1)) begin
            // Falling edge: present the next bit for the following rise.
            state_d = LOW;
            sr_d    = sr_q << 1;
            mosi_d  = sr_q[SR_W-2];
            rem_d   = rem_q - 1'b1;
          end else begin
            // Last bit keeps driving mosi through HOLD for slave hold time.
            state_d = HOLD;
            rem_d   = '0;
          end
        end
      end
      LOW: begin
        if (tmr_tick) begin
          state_d  = HIGH;
          sclk_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      HOLD: begin
        if (tmr_tick) begin
          state_d  = GAP;
          ss_n_d   = 1'b1;
          mosi_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      GAP: begin
        if (tmr_tick) begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          done_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    // Abort releases the bus immediately and finishes through GAP so the
    // slave still sees the normal inter-frame deselect time.
    if (i_abort && (state_q != IDLE) && (state_q != GAP)) begin
      state_d  = GAP;
      sclk_d   = 1'b0;
      ss_n_d   = 1'b1;
      mosi_d   = 1'b0;
      rem_d    = '0;
      ready_d  = 1'b0;
      done_d   = 1'b0;
      tmr_load = 1'b1;
    end
  end

  // State, datapath and output registers; reset deselects the slave at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign o_sclk  = sclk_q;
  assign o_mosi  = mosi_q;
  assign o_ss_n  = ss_n_q;
  assign o_ready = ready_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_rbz_spi_master.sv
// Bench for rbz_spi_master: directed frames with hand-computed expectations
// queued to a scoreboard; a slave-side monitor captures frames and checks them.
module tb_rbz_spi_master;

  localparam int CMD_W  = 4;
  localparam int DATA_W = 64;
  localparam int DIV    = 2;
  localparam int LEN_W  = $clog2(DATA_W + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [CMD_W-1:0]  i_cmd = '0;
  logic [DATA_W-1:0] i_data = '0;
  logic [LEN_W-1:0]  i_len = '0;
  logic              i_abort = 1'b0;
  logic              o_done;
  logic              o_sclk;
  logic              o_mosi;
  logic              o_ss_n;

  rbz_spi_master #(
    .CMD_W  (CMD_W),
    .DATA_W (DATA_W),
    .DIV    (DIV),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_cmd   (i_cmd),
    .i_data  (i_data),
    .i_len   (i_len),
    .i_abort (i_abort),
    .o_done  (o_done),
    .o_sclk  (o_sclk),
    .o_mosi  (o_mosi),
    .o_ss_n  (o_ss_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbits;
    logic [95:0] bits;
    int          low_len;
    bit          chk_gap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Issue one frame and queue its hand-computed expectation.
  task automatic send(input logic [3:0] c, input logic [63:0] d, input int len,
                      input bit keep_valid, input logic [95:0] exp_bits,
                      input int exp_n, input int exp_low, input bit chk_gap);
    exp_t e;
    int   n;
    e.nbits = exp_n; e.bits = exp_bits; e.low_len = exp_low; e.chk_gap = chk_gap;
    sb.push_back(e);
    i_cmd = c; i_data = d; i_len = LEN_W'(len); i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    if (!keep_valid) i_valid = 1'b0;
  endtask

  // Slave-side monitor: samples mid-cycle, captures mosi on sclk rises.
  bit          in_frame = 0, wait_done = 0, seen_end = 0;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0;
  int          nb = 0, low_cnt = 0, since = 0, hi_run = 0, frame_no = 0;
  logic [95:0] got = '0;
  exp_t        cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; wait_done = 0; seen_end = 0;
      prev_sclk = 1'b0; prev_mosi = 1'b0;
    end else begin
      if (!in_frame && !o_ss_n) begin
        in_frame = 1; nb = 0; low_cnt = 0; got = '0;
        if (sb.size() > 0 && sb[0].chk_gap && seen_end)
          check("gap_between_frames", hi_run, DIV + 1);
      end
      if (in_frame) begin
        if (o_sclk && !prev_sclk) begin
          got = {got[94:0], o_mosi};
          nb++;
        end
        if (o_sclk && prev_sclk) check("mosi_hold_while_high", o_mosi, prev_mosi);
        if (!o_ss_n) begin
          low_cnt++;
        end else begin
          in_frame = 0; hi_run = 1; seen_end = 1; since = 0; wait_done = 1;
          frame_no++;
          if (sb.size() == 0) begin
            fail_now("unexpected_frame");
          end else begin
            cur = sb.pop_front();
            $display("frame %0d: %0d bits %0h, ss_n low %0d cycles", frame_no, nb, got, low_cnt);
            check("frame_bit_count", nb, cur.nbits);
            check("frame_bits", got, cur.bits);
            check("ss_n_low_cycles", low_cnt, cur.low_len);
          end
        end
      end else begin
        if (o_sclk && !prev_sclk) fail_now("sclk_edge_outside_frame");
        if (o_ss_n) hi_run++;
        if (wait_done) begin
          since++;
          if (o_done) begin
            check("done_delay_after_ss_n_rise", since, DIV);
            check("ready_with_done", o_ready, 1'b1);
            wait_done = 0;
          end else if (since > 50) begin
            fail_now("done_timeout");
            wait_done = 0;
          end
        end else if (o_done) begin
          fail_now("spurious_done");
        end
      end
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_sclk", o_sclk, 1'b0);
    check("reset_mosi", o_mosi, 1'b0);
    check("reset_ss_n", o_ss_n, 1'b1);
    check("reset_ready", o_ready, 1'b1);
    check("reset_done", o_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // cmd A, 8-bit payload 3C: 12 bits, ss_n low 2*2*12+2 = 50, ready at 53.
    send(4'hA, 64'h3C, 8, 0, 96'hA3C, 12, 50, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_ready && k < 200);
    check("ready_return_cycle", k, 53);
    check("done_at_ready_return", o_done, 1'b1);

    // Zero-length payload: only the command 0101, ss_n low 2*2*4+2 = 18.
    send(4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 96'h5, 4, 18, 0);

    // Length 70 clamps to 64: 68-bit frame, ss_n low 2*2*68+2 = 274.
    send(4'h9, 64'hDEAD_BEEF_0123_4567, 70, 0, {28'h0, 4'h9, 64'hDEAD_BEEF_0123_4567}, 68, 274, 0);

    // Abort in the 3rd HIGH phase (cycles 11-12): bits 1,1,0 of cmd C, ss_n low 1..11.
    send(4'hC, 64'hF0, 8, 0, 96'h6, 3, 11, 0);
    repeat (11) @(negedge clk);
    check("sclk_high_before_abort", o_sclk, 1'b1);
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_ss_n", o_ss_n, 1'b1);
    check("abort_sclk", o_sclk, 1'b0);
    check("abort_mosi", o_mosi, 1'b0);

    // Back-to-back: 0011_0110 (N=8, low 34) then 1110_101101 (N=10, low 42).
    send(4'h3, 64'h6, 4, 1, 96'h36, 8, 34, 0);
    send(4'hE, 64'hFFFF_FFFF_FFFF_FFED, 6, 0, 96'h3AD, 10, 42, 1);

    // Reset in the first LOW phase (cycles 5-6) of an unqueued frame.
    k = 0;
    while (!o_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    i_cmd = 4'h6; i_data = 64'h81; i_len = LEN_W'(8); i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("ss_n_low_before_reset", o_ss_n, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ss_n", o_ss_n, 1'b1);
    check("async_reset_sclk", o_sclk, 1'b0);
    check("async_reset_ready", o_ready, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Frame after reset: 0001_01011010, low 50.
    send(4'h1, 64'h5A, 8, 0, 96'h15A, 12, 50, 0);

    k = 0;
    while ((sb.size() != 0 || wait_done || in_frame) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rbz_spi_master.md
# rbz_spi_master

SPI master that serialises register-write frames (command code plus variable-length payload) onto the 3-wire SPI interface (sclk/mosi/ss_n) consumed by the rbzero register and vector slave ports. It is used in test harnesses and companion controller designs (MCU-less demo boards, FPGA bring-up) to drive rbzero from a parallel request interface. It accepts one frame per valid/ready handshake and generates mode-0 SPI with a programmable half-period, slow enough for the slave's 2-flop input synchronisers.

## Interface
Parameters:
- CMD_W, 4, command field width in bits
- DATA_W, 64, maximum payload width in bits
- DIV, 4, SCLK half-period in clk cycles; minimum 2, enforced by elaboration check
- LEN_W, $clog2(DATA_W+1), width of i_len

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  frame request
- o_ready  out  1  high only in IDLE; a frame is accepted on a clk edge where i_valid && o_ready
- i_cmd  in  CMD_W  command code, sent MSB first
- i_data  in  DATA_W  payload, right-aligned; bits [i_len-1:0] sent MSB first
- i_len  in  LEN_W  payload bit count, 0..DATA_W
- i_abort  in  1  synchronous abort of the frame in progress
- o_done  out  1  one-cycle pulse when the controller returns to IDLE after a frame or an abort
- o_sclk  out  1  SPI clock, idle low
- o_mosi  out  1  SPI data
- o_ss_n  out  1  SPI select, active low

## Operation
- Every output is a register. Reset values: o_sclk=0, o_mosi=0, o_ss_n=1, o_ready=1, o_done=0. State resets to IDLE.
- On accept, the controller latches {i_cmd, i_data} into a shift register and latches N = CMD_W + min(i_len, DATA_W). An i_len greater than DATA_W is clamped to DATA_W.
- States:
  - IDLE → SETUP on accept.
  - SETUP (ss_n=0, sclk=0, mosi=first bit, DIV cycles) → HIGH.
  - HIGH (sclk=1, DIV cycles) → LOW if bits remain, otherwise HOLD.
  - LOW (sclk=0, mosi=next bit, DIV cycles) → HIGH.
  - HOLD (sclk=0, ss_n=0, DIV cycles) → GAP.
  - GAP (ss_n=1, DIV cycles) → IDLE, with o_done pulsed on entry to IDLE.
- Mosi changes only on the edge that drops sclk or on entry to SETUP. The slave samples on each sclk rising edge, so the frame has exactly N rising edges.
- i_abort in any state other than IDLE/GAP: next cycle goes to GAP with sclk=0, ss_n=1, mosi=0. No further rising edges occur. i_abort is ignored in IDLE and GAP.
- i_valid while busy is ignored. i_data, i_cmd and i_len are don't-care except on the accept edge.
- Reset mid-frame: ss_n rises asynchronously, and the slave discards the partial frame.

## Timing
- Accept edge = cycle 0. ss_n is low for cycles 1 through 2·DIV·N + DIV.
- Rising edge k (k=1..N) of sclk occurs at cycle 1 + (2k−1)·DIV.
- GAP covers cycles 2·DIV·N + DIV + 1 through 2·DIV·N + 2·DIV.
- o_ready and o_done are high at cycle 2·DIV·N + 2·DIV + 1.
- Back-to-back frames (i_valid held high): ss_n is high for exactly DIV + 1 cycles between frames.
- Mosi setup before the rising sclk edge is DIV cycles. Mosi hold after the edge is DIV cycles.

## Structure
- Package rbz_spi_pkg holds CMD_W, the rbzero register command-code localparams, and the state enum (IDLE, SETUP, HIGH, LOW, HOLD, GAP).
- Sub-module rbz_spi_phase_timer: a $clog2(DIV)-bit down-counter with load and a terminal-count tick. It is reloaded on every state transition.
- The top level holds the FSM, the (CMD_W+DATA_W)-bit shift register, and the $clog2(CMD_W+DATA_W+1)-bit remaining-bit counter.

## Test plan
- DIV=2, cmd=4'hA, len=8, data=8'h3C → a slave model captures 12 bits, 1010_00111100. ss_n is low for 50 cycles. o_ready returns at cycle 53, with o_done pulsed at the same cycle.
- len=0, cmd=4'h5 → exactly 4 rising edges carrying 0101, then HOLD and GAP as specified.
- len=70 with DATA_W=64 → clamped to a 68-bit frame, carrying cmd plus i_data[63:0].
- Abort asserted during the 3rd HIGH phase → ss_n=1 and sclk=0 on the next cycle. No 4th edge occurs. o_done pulses DIV cycles later.
- i_valid held high across two frames → ss_n high for exactly DIV+1 cycles between frames. The second frame's bits are correct.
- rst_n dropped mid-LOW → ss_n=1, sclk=0, o_ready=1 without waiting for a clk edge. A new frame after reset release is transmitted correctly.
